// File: rtl/muldiv_unit.sv
// Iterative RV32 multiply/divide unit: 32-step shift-add multiply and restoring
// divide, with capture-time special-case detection and a registered result.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [XLEN-1:0] srcA,
    input  logic [XLEN-1:0] srcB,
    input  logic [3:0]      alu_ctrl,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] md_result,
    output logic            is_zero
);

    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, RUN, FIXUP} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [3:0]      op_q, op_d;
    logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d, b_q, b_d;
    logic            qneg_q, qneg_d, rneg_q, rneg_d;
    logic            busy_q, busy_d, done_q, done_d, zero_q, zero_d;
    logic [XLEN-1:0] res_q, res_d;

    logic            acc_ok, in_mul, in_signed, a_neg, b_neg;
    logic            op_is_mul, op_is_rem, div_ge;
    logic [XLEN:0]   mul_sum, div_r, div_diff;
    logic [XLEN-1:0] fix_res;

    function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    assign acc_ok    = alu_ctrl[3] & (alu_ctrl[2] | alu_ctrl[1]);
    assign in_mul    = (alu_ctrl[3:1] == 3'b101);
    assign in_signed = ~in_mul & ~alu_ctrl[0];
    assign a_neg     = in_signed & srcA[XLEN-1];
    assign b_neg     = in_signed & srcB[XLEN-1];

    assign op_is_mul = (op_q[3:1] == 3'b101);
    assign op_is_rem = (op_q[3:1] == 3'b111);

    // hi holds the partial product / partial remainder, lo the multiplier / dividend bits.
    assign mul_sum  = {1'b0, hi_q} + {1'b0, (lo_q[0] ? b_q : {XLEN{1'b0}})};
    assign div_r    = {hi_q, lo_q[XLEN-1]};
    assign div_diff = div_r - {1'b0, b_q};
    assign div_ge   = ~div_diff[XLEN];

    assign fix_res = op_is_mul ? (op_q[0] ? hi_q : lo_q)
                   : (op_is_rem ? cond_neg(hi_q, rneg_q) : cond_neg(lo_q, qneg_q));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        b_d     = b_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        zero_d  = zero_q;
        res_d   = res_q;
        case (state_q)
            IDLE: begin
                if (start && acc_ok) begin
                    op_d    = alu_ctrl;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    hi_d    = '0;
                    qneg_d  = 1'b0;
                    rneg_d  = 1'b0;
                    state_d = RUN;
                    if (in_mul) begin
                        lo_d = srcB;
                        b_d  = srcA;
                    end else if (srcB == '0) begin
                        // Quotient slot gets all-ones, remainder slot the dividend.
                        lo_d    = '1;
                        hi_d    = srcA;
                        state_d = FIXUP;
                    end else if (in_signed && srcA == MIN_NEG && srcB == '1) begin
                        lo_d    = MIN_NEG;
                        state_d = FIXUP;
                    end else begin
                        lo_d   = cond_neg(srcA, a_neg);
                        b_d    = cond_neg(srcB, b_neg);
                        qneg_d = a_neg ^ b_neg;
                        rneg_d = a_neg;
                    end
                end
            end
            RUN: begin
                if (op_is_mul) begin
                    hi_d = mul_sum[XLEN:1];
                    lo_d = {mul_sum[0], lo_q[XLEN-1:1]};
                end else begin
                    hi_d = div_ge ? div_diff[XLEN-1:0] : div_r[XLEN-1:0];
                    lo_d = {lo_q[XLEN-2:0], div_ge};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(XLEN-1)) state_d = FIXUP;
            end
            FIXUP: begin
                res_d   = fix_res;
                zero_d  = (fix_res == '0);
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            b_q     <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            zero_q  <= 1'b1;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            b_q     <= b_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            zero_q  <= zero_d;
            res_q   <= res_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign md_result = res_q;
    assign is_zero   = zero_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corner cases plus random ops
// compared against an arithmetic reference model.
module tb_muldiv_unit;

    localparam logic [3:0] OP_MUL = 4'b1010, OP_MULHU = 4'b1011, OP_DIV = 4'b1100,
                           OP_DIVU = 4'b1101, OP_REM = 4'b1110, OP_REMU = 4'b1111;

    logic        clk = 1'b0;
    logic        rst, start;
    logic [31:0] srcA, srcB;
    logic [3:0]  alu_ctrl;
    logic        busy, done, is_zero;
    logic [31:0] md_result;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    muldiv_unit #(.XLEN(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .srcA      (srcA),
        .srcB      (srcB),
        .alu_ctrl  (alu_ctrl),
        .busy      (busy),
        .done      (done),
        .md_result (md_result),
        .is_zero   (is_zero)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        longint      sa, sb, r;
        p  = {32'b0, a} * {32'b0, b};
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r  = 0;
        case (op)
            OP_MUL:   return p[31:0];
            OP_MULHU: return p[63:32];
            OP_DIV:  begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                r = sa / sb;      // 64-bit math: MIN/-1 wraps to MIN when truncated
                return r[31:0];
            end
            OP_DIVU:  return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            OP_REM:  begin
                if (b == 32'd0) return a;
                r = sa % sb;
                return r[31:0];
            end
            OP_REMU:  return (b == 32'd0) ? a : a % b;
            default:  return 32'd0;
        endcase
    endfunction

    function automatic bit is_special(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op[3:1] == 3'b101) return 1'b0;
        if (b == 32'd0) return 1'b1;
        return (op == OP_DIV || op == OP_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // Called at posedge+1 with the unit idle or just signalling done.
    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp);
        int lat;
        bit special;
        special  = is_special(op, a, b);
        start    = 1'b1;
        alu_ctrl = op;
        srcA     = a;
        srcB     = b;
        @(posedge clk); #1;
        start    = 1'b0;
        srcA     = $urandom;
        srcB     = $urandom;
        alu_ctrl = 4'($urandom);
        check({tag, "/busy_after_accept"}, {31'b0, busy}, 32'd1);
        if (!special) check({tag, "/done_low_after_accept"}, {31'b0, done}, 32'd0);
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!done && lat < 40);
        check({tag, "/latency"}, 32'(lat), special ? 32'd1 : 32'd33);
        check({tag, "/result"}, md_result, exp);
        check({tag, "/is_zero"}, {31'b0, is_zero}, {31'b0, exp == 32'd0});
        check({tag, "/busy_at_done"}, {31'b0, busy}, 32'd0);
    endtask

    initial begin
        int          ndone, nbusy;
        logic [31:0] seen, a, b;
        logic [3:0]  op;
        logic [3:0]  ops [6];
        ops = '{OP_MUL, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU};

        rst = 1'b1; start = 1'b0; srcA = '0; srcB = '0; alu_ctrl = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset/busy", {31'b0, busy}, 32'd0);
        check("reset/done", {31'b0, done}, 32'd0);
        check("reset/md_result", md_result, 32'd0);
        check("reset/is_zero", {31'b0, is_zero}, 32'd1);
        rst = 1'b0;

        run_op("mul_7x6",      OP_MUL,   32'd7, 32'd6, 32'd42);
        run_op("mulhu_max",    OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run_op("mul_max",      OP_MUL,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);
        run_op("div_m7_2",     OP_DIV,   32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
        run_op("rem_m7_2",     OP_REM,   32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
        run_op("divu_100_7",   OP_DIVU,  32'd100, 32'd7, 32'd14);
        run_op("remu_100_7",   OP_REMU,  32'd100, 32'd7, 32'd2);
        run_op("div_5_0",      OP_DIV,   32'd5, 32'd0, 32'hFFFF_FFFF);
        run_op("remu_5_0",     OP_REMU,  32'd5, 32'd0, 32'd5);
        run_op("div_ovf",      OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        run_op("rem_ovf",      OP_REM,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
        run_op("rem_6_3",      OP_REM,   32'd6, 32'd3, 32'd0);
        run_op("div_7_m2",     OP_DIV,   32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD);

        // start pulsed mid-run with different operands must be ignored
        start = 1'b1; alu_ctrl = OP_DIVU; srcA = 32'd100; srcB = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        start = 1'b1; srcA = 32'd9; srcB = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        ndone = 0; seen = '0;
        for (int i = 0; i < 45; i++) begin
            @(posedge clk); #1;
            if (done) begin
                ndone++;
                seen = md_result;
            end
        end
        check("busy_start/done_count", 32'(ndone), 32'd1);
        check("busy_start/result", seen, 32'd14);
        check("busy_start/idle_after", {31'b0, busy}, 32'd0);

        // reset during RUN abandons the operation
        start = 1'b1; alu_ctrl = OP_MUL; srcA = 32'h1234; srcB = 32'h5678;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst/busy", {31'b0, busy}, 32'd0);
        check("midrst/md_result", md_result, 32'd0);
        check("midrst/is_zero", {31'b0, is_zero}, 32'd1);
        check("midrst/done", {31'b0, done}, 32'd0);
        rst = 1'b0;
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        check("midrst/no_done", 32'(ndone), 32'd0);
        run_op("mul_3x3", OP_MUL, 32'd3, 32'd3, 32'd9);

        // ALU code is not accepted
        start = 1'b1; alu_ctrl = 4'b0000; srcA = 32'd5; srcB = 32'd6;
        @(posedge clk); #1;
        start = 1'b0;
        ndone = 0; nbusy = 0;
        for (int i = 0; i < 40; i++) begin
            if (busy) nbusy++;
            @(posedge clk); #1;
            if (done) ndone++;
        end
        check("illegal/busy_count", 32'(nbusy), 32'd0);
        check("illegal/done_count", 32'(ndone), 32'd0);
        check("illegal/result_held", md_result, 32'd9);

        for (int i = 0; i < 40; i++) begin
            op = ops[$urandom_range(0, 5)];
            a  = rand_operand();
            b  = rand_operand();
            run_op($sformatf("rand%0d_op%b_%h_%h", i, op, a, b), op, a, b, model(op, a, b));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
